// File: rtl/avalon_upsizer_pkg.sv
// Shared constants and sizing helpers for the pipelined Avalon-MM width upsizer.
// Imported by avalon_bus_upsizer_pipe and upsizer_lane_fifo.
package avalon_upsizer_pkg;

  localparam int DEF_SLV_DW   = 128;
  localparam int DEF_RATIO    = 4;
  localparam int DEF_MAX_PEND = 8;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of a lane index; never narrower than one bit.
  function automatic int lane_w(input int ratio);
    return (ratio < 2) ? 1 : clog2(ratio);
  endfunction

endpackage

// File: rtl/upsizer_lane_fifo.sv
// Lane-select FIFO: remembers which narrow lane each outstanding read targets.
// Popping while empty is harmless: pointers hold and the head reads as lane 0.
module upsizer_lane_fifo
  import avalon_upsizer_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int PW    = clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = count_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    // The count is tracked separately: equal pointers alone cannot tell full from empty.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; entries are only visible after a push, and empty forces lane 0.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/avalon_bus_upsizer_pipe.sv
// Pipelined Avalon-MM width upsizer: narrow slave port to a RATIO-times wider master port.
// Define UPSIZER_RDREG_EN to register the read-return path (+1 cycle latency).
module avalon_bus_upsizer_pipe
  import avalon_upsizer_pkg::*;
#(
  parameter  int SLV_DW   = DEF_SLV_DW,
  parameter  int RATIO    = DEF_RATIO,
  parameter  int SLV_AW   = 15,
  parameter  int MST_AW   = 64,
  parameter  int MAX_PEND = DEF_MAX_PEND,
  localparam int LW       = lane_w(RATIO),
  localparam int MST_DW   = RATIO * SLV_DW,
  localparam int SLV_BW   = SLV_DW / 8,
  localparam int MST_BW   = MST_DW / 8,
  localparam int CW       = clog2(MAX_PEND) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SLV_AW-1:0] SlaveAddr_i,
  input  logic              SlaveRead_i,
  input  logic              SlaveWrite_i,
  input  logic [SLV_BW-1:0] SlaveByteEnable_i,
  input  logic [SLV_DW-1:0] SlaveWriteData_i,
  output logic [SLV_DW-1:0] SlaveReadData_o,
  output logic              SlaveReadDataValid_o,
  output logic              SlaveWaitReq_o,
  output logic [MST_AW-1:0] MasterAddr_o,
  output logic              MasterRead_o,
  output logic              MasterWrite_o,
  output logic [MST_BW-1:0] MasterByteEnable_o,
  output logic [MST_DW-1:0] MasterWriteData_o,
  input  logic [MST_DW-1:0] MasterReadData_i,
  input  logic              MasterReadDataValid_i,
  input  logic              MasterWaitReq_i,
  output logic [CW-1:0]     PendCount_o,
  output logic              ErrUnderflow_o
);

  logic [LW-1:0]     lane;
  logic [LW-1:0]     pop_lane;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic [SLV_DW-1:0] ret_data;
  logic              err_q, err_d;

  // ---------------- request path (combinational) ----------------
  assign lane              = SlaveAddr_i[LW-1:0];
  assign MasterAddr_o      = MST_AW'(SlaveAddr_i >> LW);
  assign MasterWriteData_o = {RATIO{SlaveWriteData_i}};

  always_comb begin
    MasterByteEnable_o = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (lane == LW'(k)) MasterByteEnable_o[k*SLV_BW +: SLV_BW] = SlaveByteEnable_i;
    end
  end

  // A full tracker stalls new reads; writes are never tracked and never stalled by it.
  assign MasterRead_o   = SlaveRead_i & ~fifo_full;
  assign MasterWrite_o  = SlaveWrite_i & ~SlaveRead_i;
  assign SlaveWaitReq_o = MasterWaitReq_i | (SlaveRead_i & fifo_full);
  assign push           = MasterRead_o & ~MasterWaitReq_i;

  upsizer_lane_fifo #(
    .WIDTH (LW),
    .DEPTH (MAX_PEND)
  ) u_lane_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (lane),
    .pop_i   (MasterReadDataValid_i),
    .dout_o  (pop_lane),
    .count_o (PendCount_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- read return ----------------
  always_comb begin
    ret_data = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (pop_lane == LW'(k)) ret_data = MasterReadData_i[k*SLV_DW +: SLV_DW];
    end
  end

  // Sticky until reset: a beat arrived that no outstanding read accounts for.
  assign err_d = err_q | (MasterReadDataValid_i & fifo_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign ErrUnderflow_o = err_q;

`ifdef UPSIZER_RDREG_EN
  logic              rd_valid_q, rd_valid_d;
  logic [SLV_DW-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_valid_d = MasterReadDataValid_i;
    rd_data_d  = MasterReadDataValid_i ? ret_data : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign SlaveReadDataValid_o = rd_valid_q;
  assign SlaveReadData_o      = rd_data_q;
`else
  assign SlaveReadDataValid_o = MasterReadDataValid_i;
  assign SlaveReadData_o      = ret_data;
`endif

endmodule

// File: tb/tb_avalon_bus_upsizer_pipe.sv
// Self-checking bench for avalon_bus_upsizer_pipe: directed scenarios plus random traffic
// compared against a queue-based model of outstanding read lanes.
module tb_avalon_bus_upsizer_pipe;

  localparam int SLV_DW   = 128;
  localparam int RATIO    = 4;
  localparam int SLV_AW   = 15;
  localparam int MST_AW   = 64;
  localparam int MAX_PEND = 8;
  localparam int MST_DW   = RATIO * SLV_DW;
  localparam int SLV_BW   = SLV_DW / 8;
  localparam int MST_BW   = MST_DW / 8;
  localparam int CW       = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [SLV_AW-1:0] SlaveAddr_i;
  logic              SlaveRead_i;
  logic              SlaveWrite_i;
  logic [SLV_BW-1:0] SlaveByteEnable_i;
  logic [SLV_DW-1:0] SlaveWriteData_i;
  logic [SLV_DW-1:0] SlaveReadData_o;
  logic              SlaveReadDataValid_o;
  logic              SlaveWaitReq_o;
  logic [MST_AW-1:0] MasterAddr_o;
  logic              MasterRead_o;
  logic              MasterWrite_o;
  logic [MST_BW-1:0] MasterByteEnable_o;
  logic [MST_DW-1:0] MasterWriteData_o;
  logic [MST_DW-1:0] MasterReadData_i;
  logic              MasterReadDataValid_i;
  logic              MasterWaitReq_i;
  logic [CW-1:0]     PendCount_o;
  logic              ErrUnderflow_o;

  int checks   = 0;
  int failures = 0;

  // Model: lanes of outstanding reads in issue order, plus the sticky error.
  int q[$];
  bit model_err;

  always #5 clk = ~clk;

  avalon_bus_upsizer_pipe #(
    .SLV_DW(SLV_DW), .RATIO(RATIO), .SLV_AW(SLV_AW), .MST_AW(MST_AW), .MAX_PEND(MAX_PEND)
  ) dut (
    .clk(clk), .rst(rst),
    .SlaveAddr_i(SlaveAddr_i), .SlaveRead_i(SlaveRead_i), .SlaveWrite_i(SlaveWrite_i),
    .SlaveByteEnable_i(SlaveByteEnable_i), .SlaveWriteData_i(SlaveWriteData_i),
    .SlaveReadData_o(SlaveReadData_o), .SlaveReadDataValid_o(SlaveReadDataValid_o),
    .SlaveWaitReq_o(SlaveWaitReq_o), .MasterAddr_o(MasterAddr_o),
    .MasterRead_o(MasterRead_o), .MasterWrite_o(MasterWrite_o),
    .MasterByteEnable_o(MasterByteEnable_o), .MasterWriteData_o(MasterWriteData_o),
    .MasterReadData_i(MasterReadData_i), .MasterReadDataValid_i(MasterReadDataValid_i),
    .MasterWaitReq_i(MasterWaitReq_i), .PendCount_o(PendCount_o),
    .ErrUnderflow_o(ErrUnderflow_o)
  );

  function automatic logic [MST_DW-1:0] rand_wide();
    logic [MST_DW-1:0] d;
    for (int w = 0; w < MST_DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive_idle();
    SlaveAddr_i           = '0;
    SlaveRead_i           = 1'b0;
    SlaveWrite_i          = 1'b0;
    SlaveByteEnable_i     = '0;
    SlaveWriteData_i      = '0;
    MasterReadData_i      = '0;
    MasterReadDataValid_i = 1'b0;
    MasterWaitReq_i       = 1'b0;
  endtask

  task automatic drive_read(input int addr, input bit wait_req);
    drive_idle();
    SlaveAddr_i       = SLV_AW'(addr);
    SlaveRead_i       = 1'b1;
    SlaveByteEnable_i = '1;
    MasterWaitReq_i   = wait_req;
  endtask

  // One clock of traffic with the currently driven inputs; entered and left at posedge+1.
  task automatic run_cycle();
    bit                full, exp_mread, exp_mwrite, exp_wait, exp_rv, acc;
    int                lane_m, ret_lane;
    logic [MST_AW-1:0] exp_maddr;
    logic [MST_BW-1:0] exp_be;
    logic [MST_DW-1:0] exp_wd;
    logic [SLV_DW-1:0] exp_rd;
    #1;
    full       = (q.size() == MAX_PEND);
    lane_m     = int'(SlaveAddr_i) % RATIO;
    exp_maddr  = MST_AW'(SlaveAddr_i) / RATIO;
    exp_be     = '0;
    exp_be[lane_m*SLV_BW +: SLV_BW] = SlaveByteEnable_i;
    for (int k = 0; k < RATIO; k++) exp_wd[k*SLV_DW +: SLV_DW] = SlaveWriteData_i;
    exp_mread  = SlaveRead_i && !full;
    exp_mwrite = SlaveWrite_i && !SlaveRead_i;
    exp_wait   = MasterWaitReq_i || (SlaveRead_i && full);
    acc        = exp_mread && !MasterWaitReq_i;
    exp_rv     = MasterReadDataValid_i;
    ret_lane   = (q.size() > 0) ? q[0] : 0;
    exp_rd     = MasterReadData_i[ret_lane*SLV_DW +: SLV_DW];

    checks++; if (MasterAddr_o !== exp_maddr) begin failures++;
      $display("FAIL master_addr: got %h expected %h", MasterAddr_o, exp_maddr); end
    checks++; if (MasterByteEnable_o !== exp_be) begin failures++;
      $display("FAIL master_be: got %h expected %h", MasterByteEnable_o, exp_be); end
    checks++; if (MasterWriteData_o !== exp_wd) begin failures++;
      $display("FAIL master_wdata: got %h expected %h", MasterWriteData_o, exp_wd); end
    checks++; if (MasterRead_o !== exp_mread) begin failures++;
      $display("FAIL master_read: got %b expected %b", MasterRead_o, exp_mread); end
    checks++; if (MasterWrite_o !== exp_mwrite) begin failures++;
      $display("FAIL master_write: got %b expected %b", MasterWrite_o, exp_mwrite); end
    checks++; if (SlaveWaitReq_o !== exp_wait) begin failures++;
      $display("FAIL slave_waitreq: got %b expected %b", SlaveWaitReq_o, exp_wait); end
`ifndef UPSIZER_RDREG_EN
    checks++; if (SlaveReadDataValid_o !== exp_rv) begin failures++;
      $display("FAIL rd_valid: got %b expected %b", SlaveReadDataValid_o, exp_rv); end
    if (exp_rv) begin
      checks++; if (SlaveReadData_o !== exp_rd) begin failures++;
        $display("FAIL rd_data: got %h expected %h", SlaveReadData_o, exp_rd); end
    end
`endif
    @(posedge clk);
    if (exp_rv) begin
      if (q.size() > 0) void'(q.pop_front());
      else model_err = 1'b1;
    end
    if (acc) q.push_back(lane_m);
    #1;
`ifdef UPSIZER_RDREG_EN
    checks++; if (SlaveReadDataValid_o !== exp_rv) begin failures++;
      $display("FAIL rd_valid: got %b expected %b", SlaveReadDataValid_o, exp_rv); end
    if (exp_rv) begin
      checks++; if (SlaveReadData_o !== exp_rd) begin failures++;
        $display("FAIL rd_data: got %h expected %h", SlaveReadData_o, exp_rd); end
    end
`endif
    checks++; if (PendCount_o !== CW'(q.size())) begin failures++;
      $display("FAIL pend_count: got %0d expected %0d", PendCount_o, q.size()); end
    checks++; if (ErrUnderflow_o !== model_err) begin failures++;
      $display("FAIL err_underflow: got %b expected %b", ErrUnderflow_o, model_err); end
  endtask

  task automatic return_beat(input logic [MST_DW-1:0] data);
    drive_idle();
    MasterReadData_i      = data;
    MasterReadDataValid_i = 1'b1;
    run_cycle();
  endtask

  task automatic check_pend(input string name, input int exp);
    checks++; if (PendCount_o !== CW'(exp)) begin failures++;
      $display("FAIL %s: got %0d expected %0d", name, PendCount_o, exp); end
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1'b1;
    #2;
    q.delete();
    model_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    model_err = 1'b0;
    checks++; if (PendCount_o !== '0) begin failures++;
      $display("FAIL reset_pend: got %0d expected 0", PendCount_o); end
    checks++; if (ErrUnderflow_o !== 1'b0) begin failures++;
      $display("FAIL reset_err: got %b expected 0", ErrUnderflow_o); end
    checks++; if (SlaveReadDataValid_o !== 1'b0) begin failures++;
      $display("FAIL reset_rvalid: got %b expected 0", SlaveReadDataValid_o); end
    checks++; if (SlaveReadData_o !== '0) begin failures++;
      $display("FAIL reset_rdata: got %h expected 0", SlaveReadData_o); end
    checks++; if (SlaveWaitReq_o !== 1'b0 || MasterRead_o !== 1'b0) begin failures++;
      $display("FAIL reset_req: got wait=%b read=%b expected 0 0", SlaveWaitReq_o, MasterRead_o); end
    rst = 1'b0;
  endtask

  task automatic test_write();
    logic [MST_BW-1:0] exp_be;
    drive_idle();
    SlaveAddr_i       = SLV_AW'(6);
    SlaveWrite_i      = 1'b1;
    SlaveByteEnable_i = 16'hFFFF;
    SlaveWriteData_i  = rand_wide()[SLV_DW-1:0];
    run_cycle();
    exp_be = '0;
    exp_be[2*SLV_BW +: SLV_BW] = 16'hFFFF;
    checks++; if (MasterAddr_o !== 64'h1) begin failures++;
      $display("FAIL write_addr6: got %h expected 1", MasterAddr_o); end
    checks++; if (MasterByteEnable_o !== exp_be) begin failures++;
      $display("FAIL write_be_lane2: got %h expected %h", MasterByteEnable_o, exp_be); end
    // Read and write together: read wins and is tracked.
    SlaveRead_i = 1'b1;
    run_cycle();
    return_beat(rand_wide());
  endtask

  task automatic test_read_order();
    int addrs[3] = '{1, 3, 0};
    for (int i = 0; i < 3; i++) begin
      drive_read(addrs[i], 1'b0);
      run_cycle();
      check_pend("order_pend_up", i + 1);
    end
    for (int i = 0; i < 3; i++) begin
      return_beat(rand_wide());
      check_pend("order_pend_down", 2 - i);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < MAX_PEND; i++) begin
      drive_read($urandom_range(0, 255), 1'b0);
      run_cycle();
    end
    check_pend("full_pend", MAX_PEND);
    drive_read(5, 1'b0);
    #1;
    checks++; if (SlaveWaitReq_o !== 1'b1 || MasterRead_o !== 1'b0) begin failures++;
      $display("FAIL full_stall: got wait=%b read=%b expected 1 0", SlaveWaitReq_o, MasterRead_o); end
    run_cycle();
    check_pend("full_hold", MAX_PEND);
    // Return while the read is held off: only the pop happens.
    MasterReadData_i      = rand_wide();
    MasterReadDataValid_i = 1'b1;
    run_cycle();
    check_pend("full_pop_gated", MAX_PEND - 1);
    // Now push and pop coincide: count stays.
    MasterReadData_i = rand_wide();
    run_cycle();
    check_pend("push_pop_same", MAX_PEND - 1);
    while (q.size() > 0) return_beat(rand_wide());
    check_pend("full_drained", 0);
  endtask

  task automatic test_waitreq();
    for (int i = 0; i < 3; i++) begin
      drive_read(2, 1'b1);
      run_cycle();
      check_pend("waitreq_no_push", 0);
    end
    drive_read(2, 1'b0);
    run_cycle();
    check_pend("waitreq_accept", 1);
    return_beat(rand_wide());
  endtask

  task automatic test_underflow();
    return_beat(rand_wide());
    checks++; if (ErrUnderflow_o !== 1'b1) begin failures++;
      $display("FAIL underflow_set: got %b expected 1", ErrUnderflow_o); end
    drive_idle();
    repeat (2) run_cycle();
    apply_reset();
    checks++; if (ErrUnderflow_o !== 1'b0) begin failures++;
      $display("FAIL underflow_clear: got %b expected 0", ErrUnderflow_o); end
    // Reset with reads in flight: late beats are unaccounted for.
    drive_read(1, 1'b0); run_cycle();
    drive_read(3, 1'b0); run_cycle();
    apply_reset();
    check_pend("reset_mid_pend", 0);
    return_beat(rand_wide());
    checks++; if (ErrUnderflow_o !== 1'b1) begin failures++;
      $display("FAIL late_beat_err: got %b expected 1", ErrUnderflow_o); end
    apply_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_idle();
      SlaveAddr_i           = SLV_AW'($urandom);
      SlaveRead_i           = $urandom_range(0, 1);
      SlaveWrite_i          = SlaveRead_i ? 1'b0 : 1'($urandom_range(0, 1));
      SlaveByteEnable_i     = SLV_BW'($urandom);
      SlaveWriteData_i      = rand_wide()[SLV_DW-1:0];
      MasterWaitReq_i       = ($urandom_range(0, 3) == 0);
      MasterReadData_i      = rand_wide();
      MasterReadDataValid_i = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      run_cycle();
    end
    while (q.size() > 0) return_beat(rand_wide());
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    test_reset();
    test_write();
    test_read_order();
    test_full();
    test_waitreq();
    test_underflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
